// File: rtl/writeback_arbiter_if.sv
// ----------------------------------------------------------------------------
// writeback_arbiter_if
// Bundles the four functional-unit writeback sources and the three broadcast
// writeback lanes seen by writeback_arbiter.
//
//   src_en      [3:0]   per-source writeback valid pulse
//   src_vregid  [19:0]  5-bit ROB tag per source (source i at [5i+4:5i])
//   src_dest    [19:0]  5-bit architectural destination per source
//   src_val     [127:0] 32-bit result per source (source i at [32i+31:32i])
//   src_stall   [3:0]   per-source almost-full hint back to the sources
//   overflow    [3:0]   sticky per-source drop flag
//   wbN_en/vregid/dest/val  broadcast lane N (N = 1..3)
//
// master: the producer side (functional units / testbench).
// slave : the arbiter.
// ----------------------------------------------------------------------------
interface writeback_arbiter_if;
    logic [3:0]   src_en;
    logic [19:0]  src_vregid;
    logic [19:0]  src_dest;
    logic [127:0] src_val;
    logic [3:0]   src_stall;
    logic [3:0]   overflow;

    logic         wb1_en;
    logic [4:0]   wb1_vregid;
    logic [4:0]   wb1_dest;
    logic [31:0]  wb1_val;
    logic         wb2_en;
    logic [4:0]   wb2_vregid;
    logic [4:0]   wb2_dest;
    logic [31:0]  wb2_val;
    logic         wb3_en;
    logic [4:0]   wb3_vregid;
    logic [4:0]   wb3_dest;
    logic [31:0]  wb3_val;

    modport master (
        output src_en, src_vregid, src_dest, src_val,
        input  src_stall, overflow,
        input  wb1_en, wb1_vregid, wb1_dest, wb1_val,
        input  wb2_en, wb2_vregid, wb2_dest, wb2_val,
        input  wb3_en, wb3_vregid, wb3_dest, wb3_val
    );

    modport slave (
        input  src_en, src_vregid, src_dest, src_val,
        output src_stall, overflow,
        output wb1_en, wb1_vregid, wb1_dest, wb1_val,
        output wb2_en, wb2_vregid, wb2_dest, wb2_val,
        output wb3_en, wb3_vregid, wb3_dest, wb3_val
    );
endinterface

// File: rtl/writeback_arbiter.sv
// ----------------------------------------------------------------------------
// writeback_arbiter
// Collects single-cycle writeback pulses from ALU/MUL/DIV/LSU into per-source
// FIFOs and arbitrates them round-robin onto three registered broadcast lanes.
// An idle source with an empty FIFO bypasses straight to a lane.
//
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_flush  synchronous flush: empties FIFOs, clears lanes and rr pointer
//   io_bus   writeback_arbiter_if.slave (sources in, lanes/status out)
// ----------------------------------------------------------------------------
module writeback_arbiter #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned N_SRC      = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    writeback_arbiter_if.slave    io_bus
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = $clog2(N_SRC);
    localparam int unsigned DW = 42;  // {vregid[4:0], dest[4:0], val[31:0]}
    localparam int unsigned NL = 3;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef logic [DW-1:0] payload_t;

    // State
    payload_t        r_mem     [N_SRC][FIFO_DEPTH];
    logic [PW-1:0]   r_rd_ptr  [N_SRC];
    logic [PW-1:0]   r_wr_ptr  [N_SRC];
    logic [CW-1:0]   r_count   [N_SRC];
    logic [SW-1:0]   r_rr_ptr;
    logic [N_SRC-1:0] r_overflow;
    logic [NL-1:0]   r_wb_en;
    payload_t        r_wb_data [NL];

    // Combinational
    payload_t        w_in_data   [N_SRC];
    payload_t        w_cand_data [N_SRC];
    logic [N_SRC-1:0] w_nonempty;
    logic [N_SRC-1:0] w_cand_vld;
    logic [N_SRC-1:0] w_gnt;
    logic [N_SRC-1:0] w_pop;
    logic [N_SRC-1:0] w_push;
    logic [N_SRC-1:0] w_drop;
    logic [NL-1:0]   w_lane_vld;
    payload_t        w_lane_data [NL];
    logic [SW-1:0]   w_rr_next;

    // Candidate per source: FIFO head first, else the incoming pulse.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            w_in_data[i]   = {io_bus.src_vregid[5*i +: 5], io_bus.src_dest[5*i +: 5],
                              io_bus.src_val[32*i +: 32]};
            w_nonempty[i]  = (r_count[i] != '0);
            w_cand_vld[i]  = w_nonempty[i] | io_bus.src_en[i];
            w_cand_data[i] = w_nonempty[i] ? r_mem[i][r_rd_ptr[i]] : w_in_data[i];
        end
    end

    // Round-robin scan from r_rr_ptr; the first three candidates fill lanes 1..3.
    always_comb begin
        logic [1:0]    v_lane;
        logic [SW-1:0] v_idx;
        v_lane      = '0;
        v_idx       = '0;
        w_gnt       = '0;
        w_lane_vld  = '0;
        w_lane_data = '{default: '0};
        w_rr_next   = r_rr_ptr;
        for (int k = 0; k < N_SRC; k++) begin
            v_idx = r_rr_ptr + SW'(k);
            if (w_cand_vld[v_idx] && (v_lane < 2'(NL))) begin
                w_gnt[v_idx]        = 1'b1;
                w_lane_vld[v_lane]  = 1'b1;
                w_lane_data[v_lane] = w_cand_data[v_idx];
                w_rr_next           = v_idx + SW'(1);
                v_lane              = v_lane + 2'd1;
            end
        end
    end

    // FIFO control. A granted bypass is consumed; any other pulse is queued,
    // and a full FIFO only accepts it if the head leaves in the same cycle.
    always_comb begin
        logic v_push_req;
        v_push_req = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            w_pop[i]   = w_gnt[i] & w_nonempty[i];
            v_push_req = io_bus.src_en[i] & ~(w_gnt[i] & ~w_nonempty[i]);
            w_push[i]  = v_push_req & ((r_count[i] != DEPTH_C) | w_pop[i]);
            w_drop[i]  = v_push_req & (r_count[i] == DEPTH_C) & ~w_pop[i];
            io_bus.src_stall[i] = (r_count[i] >= DEPTH_C - CW'(1));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_SRC; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_rr_ptr   <= '0;
            r_overflow <= '0;
            r_wb_en    <= '0;
            r_wb_data  <= '{default: '0};
        end else if (i_flush) begin
            // Overflow is sticky across flushes; lane payloads simply hold.
            for (int i = 0; i < N_SRC; i++) begin
                r_rd_ptr[i] <= '0;
                r_wr_ptr[i] <= '0;
                r_count[i]  <= '0;
            end
            r_rr_ptr <= '0;
            r_wb_en  <= '0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (w_pop[i]) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + PW'(1);
                end
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PW'(1);
                end
                if (w_push[i] && !w_pop[i]) begin
                    r_count[i] <= r_count[i] + CW'(1);
                end else if (!w_push[i] && w_pop[i]) begin
                    r_count[i] <= r_count[i] - CW'(1);
                end
            end
            r_overflow <= r_overflow | w_drop;
            r_rr_ptr   <= w_rr_next;
            r_wb_en    <= w_lane_vld;
            for (int l = 0; l < NL; l++) begin
                if (w_lane_vld[l]) begin
                    r_wb_data[l] <= w_lane_data[l];
                end
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by r_count alone.
    always_ff @(posedge i_clk) begin
        if (!i_flush) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (w_push[i]) begin
                    r_mem[i][r_wr_ptr[i]] <= w_in_data[i];
                end
            end
        end
    end

    assign io_bus.overflow   = r_overflow;
    assign io_bus.wb1_en     = r_wb_en[0];
    assign io_bus.wb1_vregid = r_wb_data[0][41:37];
    assign io_bus.wb1_dest   = r_wb_data[0][36:32];
    assign io_bus.wb1_val    = r_wb_data[0][31:0];
    assign io_bus.wb2_en     = r_wb_en[1];
    assign io_bus.wb2_vregid = r_wb_data[1][41:37];
    assign io_bus.wb2_dest   = r_wb_data[1][36:32];
    assign io_bus.wb2_val    = r_wb_data[1][31:0];
    assign io_bus.wb3_en     = r_wb_en[2];
    assign io_bus.wb3_vregid = r_wb_data[2][41:37];
    assign io_bus.wb3_dest   = r_wb_data[2][36:32];
    assign io_bus.wb3_val    = r_wb_data[2][31:0];

endmodule

// File: tb/tb_writeback_arbiter.sv
// ----------------------------------------------------------------------------
// tb_writeback_arbiter
// Directed and randomized stimulus for writeback_arbiter, checked against a
// queue-based reference model of the arbitration and FIFO rules.
// ----------------------------------------------------------------------------
module tb_writeback_arbiter;

    localparam int D = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    writeback_arbiter_if u_if();

    writeback_arbiter #(
        .FIFO_DEPTH (D),
        .N_SRC      (4)
    ) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (flush),
        .io_bus  (u_if.slave)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: one queue per source, lanes as (en, payload) pairs.
    logic [41:0] m_q [4][$];
    int          m_rr;
    logic [3:0]  m_ovf;
    logic        m_en   [3];
    logic [41:0] m_data [3];

    function automatic logic [41:0] pay(input int s);
        return {u_if.src_vregid[5*s +: 5], u_if.src_dest[5*s +: 5], u_if.src_val[32*s +: 32]};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++) m_q[s].delete();
        m_rr  = 0;
        m_ovf = '0;
        for (int l = 0; l < 3; l++) begin
            m_en[l]   = 1'b0;
            m_data[l] = '0;
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic [3:0]  en;
        logic [41:0] inp [4];
        bit          gnt [4];
        int          n, last, s;
        bit          was_empty;
        en = u_if.src_en;
        if (flush) begin
            for (int i = 0; i < 4; i++) m_q[i].delete();
            m_rr = 0;
            for (int l = 0; l < 3; l++) m_en[l] = 1'b0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            inp[i] = pay(i);
            gnt[i] = 1'b0;
        end
        n    = 0;
        last = 0;
        for (int k = 0; k < 4; k++) begin
            s = (m_rr + k) % 4;
            if (n < 3 && (m_q[s].size() > 0 || en[s])) begin
                m_data[n] = (m_q[s].size() > 0) ? m_q[s][0] : inp[s];
                gnt[s]    = 1'b1;
                last      = s;
                n++;
            end
        end
        for (int l = 0; l < 3; l++) m_en[l] = (l < n);
        if (n > 0) m_rr = (last + 1) % 4;
        for (int i = 0; i < 4; i++) begin
            was_empty = (m_q[i].size() == 0);
            if (gnt[i] && !was_empty) void'(m_q[i].pop_front());
            if (en[i] && !(gnt[i] && was_empty)) begin
                if (m_q[i].size() < D) m_q[i].push_back(inp[i]);
                else m_ovf[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic        g_en   [3];
        logic [41:0] g_data [3];
        logic [3:0]  exp_stall;
        g_en[0]   = u_if.wb1_en;
        g_en[1]   = u_if.wb2_en;
        g_en[2]   = u_if.wb3_en;
        g_data[0] = {u_if.wb1_vregid, u_if.wb1_dest, u_if.wb1_val};
        g_data[1] = {u_if.wb2_vregid, u_if.wb2_dest, u_if.wb2_val};
        g_data[2] = {u_if.wb3_vregid, u_if.wb3_dest, u_if.wb3_val};
        for (int l = 0; l < 3; l++) begin
            check_eq($sformatf("wb%0d_en", l + 1), 64'(g_en[l]), 64'(m_en[l]));
            check_eq($sformatf("wb%0d_payload", l + 1), 64'(g_data[l]), 64'(m_data[l]));
        end
        for (int s = 0; s < 4; s++) exp_stall[s] = (m_q[s].size() >= D - 1);
        check_eq("src_stall", 64'(u_if.src_stall), 64'(exp_stall));
        check_eq("overflow", 64'(u_if.overflow), 64'(m_ovf));
    endtask

    task automatic rand_payload();
        u_if.src_vregid = 20'($urandom);
        u_if.src_dest   = 20'($urandom);
        u_if.src_val    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic step(input logic [3:0] en, input logic fl);
        u_if.src_en = en;
        flush       = fl;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic step_rand(input logic [3:0] en, input logic fl);
        rand_payload();
        step(en, fl);
    endtask

    logic [4:0] saved_vid;
    logic [3:0] saved_ovf;

    initial begin
        u_if.src_en = '0;
        rand_payload();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        #3 rst_n = 1'b1;

        // Single bypass pulse from source 2.
        rand_payload();
        u_if.src_vregid[14:10] = 5'd7;
        u_if.src_val[95:64]    = 32'h0000_0011;
        step(4'b0100, 1'b0);
        check_eq("t1_wb1_vregid", 64'(u_if.wb1_vregid), 64'd7);
        check_eq("t1_wb1_val", 64'(u_if.wb1_val), 64'h11);
        check_eq("t1_wb2_en", 64'(u_if.wb2_en), 64'd0);
        step_rand(4'b0000, 1'b0);

        // All four at once from rr_ptr=0 (flush first to pin rr_ptr).
        step_rand(4'b0000, 1'b1);
        rand_payload();
        saved_vid = u_if.src_vregid[19:15];
        step(4'b1111, 1'b0);
        step_rand(4'b0000, 1'b0);
        check_eq("t2_wb1_src3", 64'(u_if.wb1_vregid), 64'(saved_vid));
        check_eq("t2_wb2_en", 64'(u_if.wb2_en), 64'd0);
        repeat (2) step_rand(4'b0000, 1'b0);

        // Six cycles of full contention, then drain.
        repeat (6) step_rand(4'b1111, 1'b0);
        check_eq("t3_no_ovf", 64'(u_if.overflow), 64'd0);
        repeat (8) step_rand(4'b0000, 1'b0);

        // Sustained overload must eventually drop.
        repeat (30) step_rand(4'b1111, 1'b0);
        check_eq("t4_ovf_set", 64'(u_if.overflow != 4'd0), 64'd1);

        // Flush with backlog and a concurrent source-0 pulse.
        saved_ovf = u_if.overflow;
        step_rand(4'b0001, 1'b1);
        check_eq("t5_lanes_idle", 64'({u_if.wb1_en, u_if.wb2_en, u_if.wb3_en}), 64'd0);
        check_eq("t5_stall_clr", 64'(u_if.src_stall), 64'd0);
        check_eq("t5_ovf_kept", 64'(u_if.overflow), 64'(saved_ovf));
        repeat (3) step_rand(4'b0000, 1'b0);

        // Asynchronous reset while lanes are busy.
        repeat (3) step_rand(4'b1111, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_async_en", 64'({u_if.wb1_en, u_if.wb2_en, u_if.wb3_en}), 64'd0);
        check_eq("t6_async_ovf", 64'(u_if.overflow), 64'd0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        step_rand(4'b0010, 1'b0);
        check_eq("t6_first_pulse", 64'(u_if.wb1_en), 64'd1);

        // Randomized traffic with occasional flushes.
        for (int c = 0; c < 400; c++) begin
            logic [3:0] en;
            en = 4'($urandom);
            if (c % 100 < 50) en = en & 4'($urandom);
            step_rand(en, ($urandom_range(0, 40) == 0));
        end
        repeat (8) step_rand(4'b0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
